cp0_exc_ctrl: RTL and testbench



---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_req_arb.sv | 25 ++
 rtl/cp0_exc_ctrl.sv | 131 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller:
// register numbers, exception codes, SR/Cause field positions and
// the EPC target helper.
package cp0_pkg;

   // mfc0/mtc0 register numbers
   localparam logic [4:0] CP0_REG_SR    = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
   localparam logic [4:0] CP0_REG_EPC   = 5'd14;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IE     = 0;
   localparam int SR_EXL    = 1;
   localparam int SR_IM_LO  = 10;
   localparam int SR_IM_HI  = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   // Restart PC for the faulting instruction: word-aligned M-stage PC,
   // backed up to the branch when the instruction sits in a delay slot.
   // Arithmetic wraps mod 2^32.
   function automatic logic [31:0] epc_target(input logic [31:0] pc,
                                              input logic        bd);
      logic [31:0] aligned;
      aligned = pc & 32'hFFFF_FFFC;
      return bd ? (aligned - 32'd4) : aligned;
   endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational request arbiter: qualifies interrupts and exceptions
// against SR and picks the ExcCode to record. Interrupts win.
module cp0_req_arb
   import cp0_pkg::*;
(
   input  logic [5:0] hwint_i,
   input  logic [5:0] im_i,
   input  logic       ie_i,
   input  logic       exl_i,
   input  logic [4:0] m_exccode_i,
   output logic       int_req_o,
   output logic       exc_req_o,
   output logic       req_o,
   output logic [4:0] sel_exccode_o
);

   // Request qualification and priority select
   always_comb begin
      int_req_o     = (|(hwint_i & im_i)) & ie_i & ~exl_i;
      exc_req_o     = (m_exccode_i != 5'd0) & ~exl_i;
      req_o         = int_req_o | exc_req_o;
      sel_exccode_o = int_req_o ? EXC_INT : m_exccode_i;
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception and interrupt controller at the M stage.
// Holds SR, Cause and EPC, raises req to flush/redirect the pipeline,
// and sequences EXL on exception entry and eret.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PC_RESET     = 32'h0000_3000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        cp0_we,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic [4:0]  m_exccode,
   input  logic        eret,
   input  logic [5:0]  hwint,
   output logic [31:0] cp0_rdata,
   output logic [31:0] epc_out,
   output logic        req,
   output logic [31:0] handler_pc
);

   // Architectural state
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic [4:0]  sel_exccode;
   logic [31:0] sr_view;
   logic [31:0] cause_view;

   cp0_req_arb u_arb (
      .hwint_i       (hwint),
      .im_i          (im_q),
      .ie_i          (ie_q),
      .exl_i         (exl_q),
      .m_exccode_i   (m_exccode),
      .int_req_o     (int_req),
      .exc_req_o     (exc_req),
      .req_o         (req),
      .sel_exccode_o (sel_exccode)
   );

   // Register views with unimplemented bits forced to zero
   always_comb begin
      sr_view                        = 32'd0;
      sr_view[SR_IM_HI:SR_IM_LO]     = im_q;
      sr_view[SR_EXL]                = exl_q;
      sr_view[SR_IE]                 = ie_q;
      cause_view                         = 32'd0;
      cause_view[CAUSE_BD]               = bd_q;
      cause_view[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
      cause_view[CAUSE_EXC_HI:CAUSE_EXC_LO] = exccode_q;
   end

   // mfc0 read mux: pre-edge state, no bypass of same-cycle writes
   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         CP0_REG_SR:    cp0_rdata = sr_view;
         CP0_REG_CAUSE: cp0_rdata = cause_view;
         CP0_REG_EPC:   cp0_rdata = epc_q;
         default:       cp0_rdata = 32'd0;
      endcase
   end

   assign epc_out    = epc_q;
   assign handler_pc = HANDLER_ADDR;

   // Next-state: exception entry beats eret, which beats mtc0
   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      // IP tracks the pins every cycle, req cycle included
      ip_d      = hwint;

      if (req) begin
         exl_d     = 1'b1;
         bd_d      = m_bd;
         exccode_d = sel_exccode;
         epc_d     = epc_target(m_pc, m_bd);
      end else if (eret) begin
         exl_d = 1'b0;
      end else if (cp0_we) begin
         case (cp0_addr)
            CP0_REG_SR: begin
               im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
               exl_d = cp0_wdata[SR_EXL];
               ie_d  = cp0_wdata[SR_IE];
            end
            CP0_REG_EPC: epc_d = cp0_wdata;
            default: ;
         endcase
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q      <= 6'd0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= 6'd0;
         exccode_q <= 5'd0;
         epc_q     <= PC_RESET;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exception entry, delay-slot EPC,
// interrupt priority, nesting block, mtc0 collision, masking, reset.
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        cp0_we;
   logic [31:0] m_pc;
   logic        m_bd;
   logic [4:0]  m_exccode;
   logic        eret;
   logic [5:0]  hwint;
   logic [31:0] cp0_rdata;
   logic [31:0] epc_out;
   logic        req;
   logic [31:0] handler_pc;

   int errors = 0;
   int checks = 0;

   cp0_exc_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cp0_addr   (cp0_addr),
      .cp0_wdata  (cp0_wdata),
      .cp0_we     (cp0_we),
      .m_pc       (m_pc),
      .m_bd       (m_bd),
      .m_exccode  (m_exccode),
      .eret       (eret),
      .hwint      (hwint),
      .cp0_rdata  (cp0_rdata),
      .epc_out    (epc_out),
      .req        (req),
      .handler_pc (handler_pc)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cp0_addr = a;
      #1;
      chk(tag, cp0_rdata, exp);
   endtask

   initial begin
      reset = 1'b1; cp0_addr = 5'd0; cp0_wdata = 32'd0; cp0_we = 1'b0;
      m_pc = 32'd0; m_bd = 1'b0; m_exccode = 5'd0; eret = 1'b0; hwint = 6'd0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_handler", handler_pc, 32'h0000_4180);
      chk("rst_epc_out", epc_out, 32'h0000_3000);
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);
      rd("rst_epc", 5'd14, 32'h0000_3000);

      // AdEL capture
      step();
      m_exccode = 5'd4; m_pc = 32'h3010; m_bd = 1'b0;
      #1;
      chk("adel_req", {31'd0, req}, 32'd1);
      step();
      m_exccode = 5'd0;
      #1;
      chk("adel_req_drop", {31'd0, req}, 32'd0);
      chk("adel_epc", epc_out, 32'h0000_3010);
      rd("adel_cause", 5'd13, 32'h0000_0010);
      rd("adel_sr", 5'd12, 32'h0000_0002);
      eret = 1'b1;
      step();
      eret = 1'b0;
      rd("eret_sr", 5'd12, 32'd0);

      // Interrupt in a delay slot
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
      step();
      cp0_we = 1'b0;
      rd("mtc0_sr", 5'd12, 32'h0000_0401);
      hwint = 6'b000001; m_pc = 32'h3024; m_bd = 1'b1;
      #1;
      chk("dsint_req", {31'd0, req}, 32'd1);
      step();
      chk("dsint_epc", epc_out, 32'h0000_3020);
      rd("dsint_cause", 5'd13, 32'h8000_0400);
      rd("dsint_sr", 5'd12, 32'h0000_0403);
      hwint = 6'd0; m_bd = 1'b0; eret = 1'b1;
      step();
      eret = 1'b0;
      rd("dsint_eret_sr", 5'd12, 32'h0000_0401);

      // Simultaneous interrupt and AdES: interrupt wins, single pulse
      hwint = 6'b000001; m_exccode = 5'd5; m_pc = 32'h3040;
      #1;
      chk("sim_req", {31'd0, req}, 32'd1);
      step();
      chk("sim_req_single", {31'd0, req}, 32'd0);
      chk("sim_epc", epc_out, 32'h0000_3040);
      rd("sim_cause", 5'd13, 32'h0000_0400);

      // Nesting blocked while EXL=1
      m_exccode = 5'd12; m_pc = 32'h3050;
      #1;
      chk("nest_blk0", {31'd0, req}, 32'd0);
      step();
      chk("nest_blk1", {31'd0, req}, 32'd0);
      m_exccode = 5'd0; hwint = 6'd0; eret = 1'b1;
      #1;
      chk("nest_eret_req", {31'd0, req}, 32'd0);
      step();
      eret = 1'b0; m_exccode = 5'd12;
      #1;
      chk("nest_after_eret", {31'd0, req}, 32'd1);
      step();
      m_exccode = 5'd0;
      chk("nest_epc", epc_out, 32'h0000_3050);
      rd("nest_cause", 5'd13, 32'h0000_0030);
      eret = 1'b1;
      step();
      eret = 1'b0;

      // mtc0 EPC colliding with an RI exception is dropped
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
      m_exccode = 5'd10; m_pc = 32'h3060;
      #1;
      chk("coll_req", {31'd0, req}, 32'd1);
      step();
      cp0_we = 1'b0; m_exccode = 5'd0;
      chk("coll_epc", epc_out, 32'h0000_3060);
      rd("coll_cause", 5'd13, 32'h0000_0028);
      eret = 1'b1;
      step();
      eret = 1'b0;

      // Plain mtc0 to EPC lands; mtc0 to Cause is ignored
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
      step();
      cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      chk("mtc0_epc", epc_out, 32'h0000_1234);
      step();
      cp0_we = 1'b0;
      rd("mtc0_cause_ign", 5'd13, 32'h0000_0028);

      // EPC wrap: pc=0 in a delay slot
      m_pc = 32'd0; m_bd = 1'b1; m_exccode = 5'd12;
      step();
      m_exccode = 5'd0; m_bd = 1'b0;
      chk("wrap_epc", epc_out, 32'hFFFF_FFFC);

      // Reset mid-handler (EXL=1), with interrupts pending
      hwint = 6'b111111; reset = 1'b1;
      step();
      reset = 1'b0;
      rd("mid_rst_sr", 5'd12, 32'd0);
      rd("mid_rst_cause", 5'd13, 32'd0);
      chk("mid_rst_epc", epc_out, 32'h0000_3000);
      chk("masked_req", {31'd0, req}, 32'd0);
      step();
      rd("masked_ip", 5'd13, 32'h0000_FC00);
      chk("masked_req2", {31'd0, req}, 32'd0);
      rd("odd_addr", 5'd7, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
